// File: rtl/ft_bus_arbiter.sv
// FT600 245-sync FIFO bus arbiter: alternates bounded TX/RX bursts with a turnaround gap.
// Optional FT_ARB_STATS_EN adds free-running TX/RX beat counters on tx_beats/rx_beats.
module ft_bus_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BE_W      = 2,
    parameter int unsigned BURST_MAX = 2048,
    parameter int unsigned TURN_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxf_n,
    input  logic              txe_n,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_oe,
    input  logic [BE_W-1:0]   be_i,
    output logic [BE_W-1:0]   be_o,
    output logic              oe_n,
    output logic              rd_n,
    output logic              wr_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic [BE_W-1:0]   rx_be,
    input  logic              rx_ready,
    output logic [2:0]        state_o,
    output logic [31:0]       tx_beats,
    output logic [31:0]       rx_beats
);

    localparam int unsigned CntW  = $clog2(BURST_MAX) + 1;
    localparam int unsigned TurnW = $clog2(TURN_CYC) + 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(BURST_MAX - 1);
    localparam logic [TurnW-1:0] TurnLast = TurnW'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StTx   = 3'd1,
        StRxOe = 3'd2,
        StRx   = 3'd3,
        StTurn = 3'd4
    } state_e;

    state_e            r_state, w_state_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic [TurnW-1:0]  r_turn, w_turn_d;
    logic              r_last_tx, w_last_tx_d;
    logic              r_data_oe;
    logic              w_tx_req, w_rx_req, w_tx_beat, w_rx_beat;

    assign w_tx_req  = tx_valid && !txe_n;
    assign w_rx_req  = !rxf_n && rx_ready;
    assign w_tx_beat = (r_state == StTx) && tx_valid && !txe_n;
    assign w_rx_beat = (r_state == StRx) && !rxf_n && rx_ready;

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_turn_d    = r_turn;
        w_last_tx_d = r_last_tx;
        case (r_state)
            StIdle: begin
                // On a tie, go opposite to the previous burst direction.
                if (w_tx_req && (!w_rx_req || !r_last_tx)) begin
                    w_state_d   = StTx;
                    w_cnt_d     = '0;
                    w_last_tx_d = 1'b1;
                end else if (w_rx_req) begin
                    w_state_d   = StRxOe;
                    w_cnt_d     = '0;
                    w_last_tx_d = 1'b0;
                end
            end
            StTx: begin
                if (w_tx_beat) w_cnt_d = r_cnt + 1'b1;
                if (txe_n || !tx_valid || (w_tx_beat && r_cnt == CntLast)) begin
                    w_state_d = StTurn;
                    w_turn_d  = '0;
                end
            end
            StRxOe: w_state_d = StRx;
            StRx: begin
                if (w_rx_beat) w_cnt_d = r_cnt + 1'b1;
                if (rxf_n || !rx_ready || (w_rx_beat && r_cnt == CntLast)) begin
                    w_state_d = StTurn;
                    w_turn_d  = '0;
                end
            end
            StTurn: begin
                if (r_turn == TurnLast) w_state_d = StIdle;
                else                    w_turn_d  = r_turn + 1'b1;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_turn    <= '0;
            r_last_tx <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_turn    <= w_turn_d;
            r_last_tx <= w_last_tx_d;
            r_data_oe <= (w_state_d == StTx);
        end
    end

    // Strobes are decoded from state so an async reset releases them immediately.
    always_comb begin
        oe_n     = 1'b1;
        rd_n     = 1'b1;
        wr_n     = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        case (r_state)
            StTx: begin
                tx_ready = !txe_n;
                wr_n     = !w_tx_beat;
            end
            StRxOe: oe_n = 1'b0;
            StRx: begin
                oe_n     = 1'b0;
                rd_n     = !rx_ready;
                rx_valid = !rxf_n;
            end
            default: ;
        endcase
    end

    assign data_oe = r_data_oe;
    assign data_o  = tx_data;
    assign be_o    = '1;
    assign rx_data = data_i;
    assign rx_be   = be_i;
    assign state_o = r_state;

`ifdef FT_ARB_STATS_EN
    logic [31:0] r_tx_beats, r_rx_beats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_beats <= '0;
            r_rx_beats <= '0;
        end else begin
            if (w_tx_beat) r_tx_beats <= r_tx_beats + 32'd1;
            if (w_rx_beat) r_rx_beats <= r_rx_beats + 32'd1;
        end
    end

    assign tx_beats = r_tx_beats;
    assign rx_beats = r_rx_beats;
`else
    assign tx_beats = '0;
    assign rx_beats = '0;
`endif

endmodule

// File: tb/tb_ft_bus_arbiter.sv
// Directed bench for ft_bus_arbiter with BURST_MAX=4, TURN_CYC=1.
module tb_ft_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        rxf_n, txe_n;
    logic [15:0] data_i, data_o;
    logic        data_oe;
    logic [1:0]  be_i, be_o;
    logic        oe_n, rd_n, wr_n;
    logic        tx_valid, tx_ready;
    logic [15:0] tx_data;
    logic        rx_valid, rx_ready;
    logic [15:0] rx_data;
    logic [1:0]  rx_be;
    logic [2:0]  state_o;
    logic [31:0] tx_beats, rx_beats;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

`ifdef FT_ARB_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    ft_bus_arbiter #(
        .DATA_W   (16),
        .BE_W     (2),
        .BURST_MAX(4),
        .TURN_CYC (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxf_n   (rxf_n),
        .txe_n   (txe_n),
        .data_i  (data_i),
        .data_o  (data_o),
        .data_oe (data_oe),
        .be_i    (be_i),
        .be_o    (be_o),
        .oe_n    (oe_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_be   (rx_be),
        .rx_ready(rx_ready),
        .state_o (state_o),
        .tx_beats(tx_beats),
        .rx_beats(rx_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock, sample 1 time unit later, and check the drive/OE exclusion.
    task automatic step();
        @(posedge clk);
        #1;
        chk("oe_excl", 32'(data_oe & ~oe_n), 32'd0);
    endtask

    int unsigned exp_seq [14] = '{1, 1, 1, 1, 4, 0, 2, 3, 3, 3, 3, 4, 0, 1};

    initial begin
        rst_n    = 1'b0;
        rxf_n    = 1'b1;
        txe_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 16'h0;
        rx_ready = 1'b0;
        data_i   = 16'h0;
        be_i     = 2'b00;
        #2;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_rd_n", 32'(rd_n), 32'd1);
        chk("rst_wr_n", 32'(wr_n), 32'd1);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // TX only: four-beat burst, one TURN cycle, back to TX
        txe_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 16'hA5A5;
        #1;
        chk("idle_state", 32'(state_o), 32'd0);
        chk("idle_wr_n", 32'(wr_n), 32'd1);
        step();
        chk("tx_state", 32'(state_o), 32'd1);
        chk("tx_data_oe", 32'(data_oe), 32'd1);
        chk("tx_wr_n", 32'(wr_n), 32'd0);
        chk("tx_ready", 32'(tx_ready), 32'd1);
        chk("tx_data_o", 32'(data_o), 32'hA5A5);
        chk("tx_be_o", 32'(be_o), 32'd3);
        chk("tx_oe_n", 32'(oe_n), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("tx_burst_state", 32'(state_o), 32'd1);
            chk("tx_burst_wr_n", 32'(wr_n), 32'd0);
        end
        step();
        chk("tx_turn_state", 32'(state_o), 32'd4);
        chk("tx_turn_data_oe", 32'(data_oe), 32'd0);
        chk("tx_turn_wr_n", 32'(wr_n), 32'd1);
        step();
        chk("tx_idle_state", 32'(state_o), 32'd0);
        step();
        chk("tx_reenter", 32'(state_o), 32'd1);

        // TX flag drop after two beats
        step();
        step();
        txe_n = 1'b1;
        #1;
        chk("txdrop_wr_n", 32'(wr_n), 32'd1);
        chk("txdrop_ready", 32'(tx_ready), 32'd0);
        step();
        chk("txdrop_turn", 32'(state_o), 32'd4);
        tx_valid = 1'b0;
        step();
        chk("txdrop_idle", 32'(state_o), 32'd0);
        chk("tx_beats", tx_beats, StatsEn ? 32'd6 : 32'd0);

        // RX only: RX_OE then four beats
        rxf_n    = 1'b0;
        rx_ready = 1'b1;
        be_i     = 2'b01;
        step();
        chk("rxoe_state", 32'(state_o), 32'd2);
        chk("rxoe_oe_n", 32'(oe_n), 32'd0);
        chk("rxoe_rd_n", 32'(rd_n), 32'd1);
        chk("rxoe_data_oe", 32'(data_oe), 32'd0);
        chk("rxoe_rx_valid", 32'(rx_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            data_i = 16'h1000 + 16'(i);
            step();
            chk("rx_state", 32'(state_o), 32'd3);
            chk("rx_rd_n", 32'(rd_n), 32'd0);
            chk("rx_valid", 32'(rx_valid), 32'd1);
            chk("rx_data", 32'(rx_data), 32'h1000 + i);
            chk("rx_be", 32'(rx_be), 32'd1);
        end
        step();
        chk("rx_turn_state", 32'(state_o), 32'd4);
        chk("rx_turn_oe_n", 32'(oe_n), 32'd1);
        chk("rx_turn_rd_n", 32'(rd_n), 32'd1);

        // Backpressure on the second RX cycle
        step();
        step();
        step();
        chk("bp_rx_state", 32'(state_o), 32'd3);
        step();
        rx_ready = 1'b0;
        #1;
        chk("bp_rd_n", 32'(rd_n), 32'd1);
        chk("bp_rx_valid", 32'(rx_valid), 32'd1);
        step();
        chk("bp_turn", 32'(state_o), 32'd4);

        // RX flag drop after two beats
        rx_ready = 1'b1;
        step();
        step();
        step();
        step();
        step();
        chk("rxdrop_state", 32'(state_o), 32'd3);
        rxf_n = 1'b1;
        #1;
        chk("rxdrop_rx_valid", 32'(rx_valid), 32'd0);
        step();
        chk("rxdrop_turn", 32'(state_o), 32'd4);
        rx_ready = 1'b0;
        step();
        chk("rx_beats", rx_beats, StatsEn ? 32'd7 : 32'd0);

        // Contention from reset: TX first, then alternate
        rst_n    = 1'b0;
        txe_n    = 1'b0;
        tx_valid = 1'b1;
        rxf_n    = 1'b0;
        rx_ready = 1'b1;
        #2;
        chk("rst_tx_beats", tx_beats, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("contend_state", 32'(state_o), 32'(exp_seq[i]));
        end

        // Async reset in the middle of a TX burst
        chk("pre_rst_wr_n", 32'(wr_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_n", 32'(wr_n), 32'd1);
        chk("arst_data_oe", 32'(data_oe), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_tx_beats", tx_beats, 32'd0);
        chk("arst_rx_beats", rx_beats, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
